kyber_bram_xfer_ctrl: RTL and testbench

Parametrised successor to the Kyber AXI/BRAM glue. It owns port B of the shared dual-port buffer BRAM and a small register file on the AXI-BRAM port-A register window. It sequences per-mode operand load (BRAM→core), core run, and result store (core→BRAM) through word-serial core ports instead of flat multi-kbit buses. It sits between axi_ctrl_wrapper/kyber_bram_wrapper and the Kyber top core.

---
 rtl/kyber_xfer_pkg.sv | 49 ++++
 rtl/kyber_xfer_seg_seq.sv | 74 +++++++
 rtl/kyber_bram_xfer_ctrl.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_kyber_bram_xfer_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_xfer_pkg.sv
// Shared types and constants for the Kyber BRAM transfer controller.
// Holds FSM state encoding, register indices, operand/result select codes
// and the segment descriptor used to walk per-mode load/store lists.
package kyber_xfer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_KICK  = 3'd2,
      ST_RUN   = 3'd3,
      ST_STORE = 3'd4
   } state_t;

   // register window indices
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_MODE   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_PERF   = 2'd3;

   // operand (load) and result (store) select codes; results use the low 2 bits
   localparam logic [2:0] SEL_PK   = 3'd0;
   localparam logic [2:0] SEL_SK   = 3'd1;
   localparam logic [2:0] SEL_C    = 3'd2;
   localparam logic [2:0] SEL_M    = 3'd3;
   localparam logic [2:0] SEL_COIN = 3'd4;

   localparam logic [1:0] MODE_KEYGEN  = 2'd0;
   localparam logic [1:0] MODE_ENCAPS  = 2'd1;
   localparam logic [1:0] MODE_DECAPS  = 2'd2;
   localparam logic [1:0] MODE_ILLEGAL = 2'd3;

   localparam int SEG_BASE_W = 16;
   localparam int WIDX_W     = 7;

   typedef struct packed {
      logic [2:0]            sel;
      logic [SEG_BASE_W-1:0] base;
      logic [WIDX_W-1:0]     words;
   } seg_t;

   function automatic seg_t mk_seg(input logic [2:0] sel, input int base, input int words);
      seg_t s;
      s.sel   = sel;
      s.base  = SEG_BASE_W'(base);
      s.words = WIDX_W'(words);
      return s;
   endfunction

endpackage

// File: rtl/kyber_xfer_seg_seq.sv
// Segment sequencer: maps (mode, direction, segment index) to a segment descriptor.
// Latency: purely combinational.
// Backpressure: none; the caller advances the segment index.
module kyber_xfer_seg_seq
   import kyber_xfer_pkg::*;
#(
   parameter int PK_WORDS    = 50,
   parameter int SK_WORDS    = 48,
   parameter int C_WORDS     = 48,
   parameter int M_WORDS     = 2,
   parameter int COIN_WORDS  = 2,
   parameter int PK_IN_BASE  = 0,
   parameter int M_IN_BASE   = 50,
   parameter int COIN_BASE   = 52,
   parameter int SK_IN_BASE  = 54,
   parameter int C_IN_BASE   = 102,
   parameter int PK_OUT_BASE = 256,
   parameter int SK_OUT_BASE = 306,
   parameter int C_OUT_BASE  = 354,
   parameter int M_OUT_BASE  = 402
)(
   input  logic [1:0] mode,
   input  logic       dir,      // 0 = load (BRAM to core), 1 = store (core to BRAM)
   input  logic [1:0] seg_idx,
   output seg_t       seg,
   output logic       last
);

   // descriptor lookup for the per-mode load and store lists
   always_comb begin
      seg  = '0;
      last = 1'b1;
      if (!dir) begin
         case (mode)
            MODE_KEYGEN: seg = mk_seg(SEL_COIN, COIN_BASE, COIN_WORDS);
            MODE_ENCAPS: begin
               if (seg_idx == 2'd0) begin
                  seg  = mk_seg(SEL_PK, PK_IN_BASE, PK_WORDS);
                  last = 1'b0;
               end else if (seg_idx == 2'd1) begin
                  seg  = mk_seg(SEL_M, M_IN_BASE, M_WORDS);
                  last = 1'b0;
               end else begin
                  seg  = mk_seg(SEL_COIN, COIN_BASE, COIN_WORDS);
               end
            end
            MODE_DECAPS: begin
               if (seg_idx == 2'd0) begin
                  seg  = mk_seg(SEL_SK, SK_IN_BASE, SK_WORDS);
                  last = 1'b0;
               end else begin
                  seg  = mk_seg(SEL_C, C_IN_BASE, C_WORDS);
               end
            end
            default: seg = '0;
         endcase
      end else begin
         case (mode)
            MODE_KEYGEN: begin
               if (seg_idx == 2'd0) begin
                  seg  = mk_seg(SEL_PK, PK_OUT_BASE, PK_WORDS);
                  last = 1'b0;
               end else begin
                  seg  = mk_seg(SEL_SK, SK_OUT_BASE, SK_WORDS);
               end
            end
            MODE_ENCAPS: seg = mk_seg(SEL_C, C_OUT_BASE, C_WORDS);
            MODE_DECAPS: seg = mk_seg(SEL_M, M_OUT_BASE, M_WORDS);
            default:     seg = '0;
         endcase
      end
   end

endmodule

// File: rtl/kyber_bram_xfer_ctrl.sv
// Kyber BRAM port-B transfer controller: operand load, core run, result store.
// Latency: N+1 cycles for an N-word load, 1 kick cycle, 1 cycle per stored word.
// Backpressure: none; BRAM and core ports are always ready. KYBER_XFER_PERF_EN adds a RUN-cycle counter at register 3.
module kyber_bram_xfer_ctrl
   import kyber_xfer_pkg::*;
#(
   parameter int DATA_W      = 128,
   parameter int ADDR_W      = 9,
   parameter int PK_WORDS    = 50,
   parameter int SK_WORDS    = 48,
   parameter int C_WORDS     = 48,
   parameter int M_WORDS     = 2,
   parameter int COIN_WORDS  = 2,
   parameter int PK_IN_BASE  = 0,
   parameter int M_IN_BASE   = 50,
   parameter int COIN_BASE   = 52,
   parameter int SK_IN_BASE  = 54,
   parameter int C_IN_BASE   = 102,
   parameter int PK_OUT_BASE = 256,
   parameter int SK_OUT_BASE = 306,
   parameter int C_OUT_BASE  = 354,
   parameter int M_OUT_BASE  = 402
)(
   input  logic              bram_clk_a,
   input  logic              bram_rst_a,
   input  logic              reg_en,
   input  logic              reg_we,
   input  logic [1:0]        reg_addr,
   input  logic [DATA_W-1:0] reg_wdata,
   output logic [DATA_W-1:0] reg_rdata,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wdata,
   input  logic [DATA_W-1:0] bram_rdata,
   output logic              core_start,
   output logic [1:0]        core_mode,
   input  logic              core_finish,
   output logic              core_wr_en,
   output logic [2:0]        core_wr_sel,
   output logic [6:0]        core_wr_idx,
   output logic [DATA_W-1:0] core_wr_data,
   output logic [1:0]        core_rd_sel,
   output logic [6:0]        core_rd_idx,
   input  logic [DATA_W-1:0] core_rd_data,
   output logic              irq
);

   state_t            state;
   logic [1:0]        seg_idx;
   logic [6:0]        word_idx;
   logic              issuing;      // LOAD still has reads to issue; clear = drain cycle
   logic              ctrl_ie;
   logic [1:0]        mode_reg;
   logic              st_done;
   logic              st_err;
   logic              busy;
   logic              ctrl_wr;
   logic              mode_wr;
   logic              status_wr;
   logic              start_req;
   logic              start_ok;

   logic [1:0]        seq_mode;
   logic              seq_dir;
   seg_t              cur_seg;
   seg_t              nxt_seg;
   logic              cur_last;
   logic              nxt_last;

   logic              last_word;
   logic              at_end;
   logic [1:0]        adv_seg_idx;
   logic [6:0]        adv_idx;
   logic [15:0]       adv_base;
   logic [1:0]        adv_rsel;
   logic [ADDR_W-1:0] adv_addr;
   logic [ADDR_W-1:0] first_addr;

   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] perf_val;
   logic              unused_bits;

   assign busy      = (state != ST_IDLE);
   assign ctrl_wr   = reg_en && reg_we && (reg_addr == REG_CTRL);
   assign mode_wr   = reg_en && reg_we && (reg_addr == REG_MODE);
   assign status_wr = reg_en && reg_we && (reg_addr == REG_STATUS);
   assign start_req = ctrl_wr && reg_wdata[0] && (state == ST_IDLE);
   assign start_ok  = start_req && (mode_reg != MODE_ILLEGAL);

   // before an operation is accepted the sequencer must see the programmed mode
   assign seq_mode = (state == ST_IDLE) ? mode_reg : core_mode;
   assign seq_dir  = (state == ST_RUN) || (state == ST_STORE);

   kyber_xfer_seg_seq #(
      .PK_WORDS(PK_WORDS), .SK_WORDS(SK_WORDS), .C_WORDS(C_WORDS),
      .M_WORDS(M_WORDS), .COIN_WORDS(COIN_WORDS),
      .PK_IN_BASE(PK_IN_BASE), .M_IN_BASE(M_IN_BASE), .COIN_BASE(COIN_BASE),
      .SK_IN_BASE(SK_IN_BASE), .C_IN_BASE(C_IN_BASE),
      .PK_OUT_BASE(PK_OUT_BASE), .SK_OUT_BASE(SK_OUT_BASE),
      .C_OUT_BASE(C_OUT_BASE), .M_OUT_BASE(M_OUT_BASE)
   ) u_cur_seg (
      .mode(seq_mode), .dir(seq_dir), .seg_idx(seg_idx), .seg(cur_seg), .last(cur_last)
   );

   // lookahead so a segment change needs no gap cycle
   kyber_xfer_seg_seq #(
      .PK_WORDS(PK_WORDS), .SK_WORDS(SK_WORDS), .C_WORDS(C_WORDS),
      .M_WORDS(M_WORDS), .COIN_WORDS(COIN_WORDS),
      .PK_IN_BASE(PK_IN_BASE), .M_IN_BASE(M_IN_BASE), .COIN_BASE(COIN_BASE),
      .SK_IN_BASE(SK_IN_BASE), .C_IN_BASE(C_IN_BASE),
      .PK_OUT_BASE(PK_OUT_BASE), .SK_OUT_BASE(SK_OUT_BASE),
      .C_OUT_BASE(C_OUT_BASE), .M_OUT_BASE(M_OUT_BASE)
   ) u_nxt_seg (
      .mode(seq_mode), .dir(seq_dir), .seg_idx(adv_seg_idx), .seg(nxt_seg), .last(nxt_last)
   );

   assign last_word   = (word_idx == (cur_seg.words - 7'd1));
   assign at_end      = last_word && cur_last;
   assign adv_seg_idx = last_word ? (seg_idx + 2'd1) : seg_idx;
   assign adv_idx     = last_word ? 7'd0 : (word_idx + 7'd1);
   assign adv_base    = last_word ? nxt_seg.base : cur_seg.base;
   assign adv_rsel    = last_word ? nxt_seg.sel[1:0] : cur_seg.sel[1:0];
   assign adv_addr    = adv_base[ADDR_W-1:0] + ADDR_W'(adv_idx);
   assign first_addr  = cur_seg.base[ADDR_W-1:0];

   // load data is forwarded straight from BRAM in the cycle it returns;
   // store data is taken straight from the core for the index presented this cycle
   assign core_wr_data = core_wr_en ? bram_rdata : '0;
   assign bram_wdata   = bram_we ? core_rd_data : '0;

   assign unused_bits = ^{reg_wdata, cur_seg.base, nxt_seg, nxt_last};

   // transfer sequencer with registered BRAM/core strobes and sticky status bits
   always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
      if (bram_rst_a) begin
         state       <= ST_IDLE;
         seg_idx     <= 2'd0;
         word_idx    <= 7'd0;
         issuing     <= 1'b0;
         bram_en     <= 1'b0;
         bram_we     <= 1'b0;
         bram_addr   <= '0;
         core_start  <= 1'b0;
         core_mode   <= 2'd0;
         core_wr_en  <= 1'b0;
         core_wr_sel <= 3'd0;
         core_wr_idx <= 7'd0;
         core_rd_sel <= 2'd0;
         core_rd_idx <= 7'd0;
         st_done     <= 1'b0;
         st_err      <= 1'b0;
      end else begin
         core_start <= 1'b0;
         core_wr_en <= 1'b0;
         if (status_wr) begin
            if (reg_wdata[1]) st_done <= 1'b0;
            if (reg_wdata[2]) st_err  <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (start_req) begin
                  if (mode_reg == MODE_ILLEGAL) begin
                     st_err <= 1'b1;
                  end else begin
                     core_mode <= mode_reg;
                     st_done   <= 1'b0;
                     state     <= ST_LOAD;
                     bram_en   <= 1'b1;
                     bram_we   <= 1'b0;
                     bram_addr <= first_addr;
                     seg_idx   <= 2'd0;
                     word_idx  <= 7'd0;
                     issuing   <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (issuing) begin
                  // the word being read now lands at the core next cycle
                  core_wr_en  <= 1'b1;
                  core_wr_sel <= cur_seg.sel;
                  core_wr_idx <= word_idx;
                  if (at_end) begin
                     issuing   <= 1'b0;
                     bram_en   <= 1'b0;
                     bram_addr <= '0;
                  end else begin
                     seg_idx   <= adv_seg_idx;
                     word_idx  <= adv_idx;
                     bram_addr <= adv_addr;
                  end
               end else begin
                  state      <= ST_KICK;
                  core_start <= 1'b1;
                  seg_idx    <= 2'd0;
                  word_idx   <= 7'd0;
               end
            end
            ST_KICK: state <= ST_RUN;
            ST_RUN: begin
               if (core_finish) begin
                  state       <= ST_STORE;
                  bram_en     <= 1'b1;
                  bram_we     <= 1'b1;
                  bram_addr   <= first_addr;
                  core_rd_sel <= cur_seg.sel[1:0];
                  core_rd_idx <= 7'd0;
                  seg_idx     <= 2'd0;
                  word_idx    <= 7'd0;
               end
            end
            ST_STORE: begin
               if (at_end) begin
                  state       <= ST_IDLE;
                  bram_en     <= 1'b0;
                  bram_we     <= 1'b0;
                  bram_addr   <= '0;
                  core_rd_sel <= 2'd0;
                  core_rd_idx <= 7'd0;
                  seg_idx     <= 2'd0;
                  word_idx    <= 7'd0;
                  st_done     <= 1'b1;
               end else begin
                  seg_idx     <= adv_seg_idx;
                  word_idx    <= adv_idx;
                  bram_addr   <= adv_addr;
                  core_rd_sel <= adv_rsel;
                  core_rd_idx <= adv_idx;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // interrupt enable is always writable; mode is frozen while an operation runs
   always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
      if (bram_rst_a) begin
         ctrl_ie  <= 1'b0;
         mode_reg <= 2'd0;
      end else begin
         if (ctrl_wr) ctrl_ie <= reg_wdata[1];
         if (mode_wr && !busy) mode_reg <= reg_wdata[1:0];
      end
   end

`ifdef KYBER_XFER_PERF_EN
   logic [31:0] perf_cnt;

   // RUN-cycle counter for the most recent operation, saturating
   always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
      if (bram_rst_a) begin
         perf_cnt <= 32'd0;
      end else if (start_ok) begin
         perf_cnt <= 32'd0;
      end else if ((state == ST_RUN) && (perf_cnt != 32'hFFFF_FFFF)) begin
         perf_cnt <= perf_cnt + 32'd1;
      end
   end

   assign perf_val = DATA_W'(perf_cnt);
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
   assign perf_val = '0;
`endif

   // register read mux; start bit is self-clearing so it always reads 0
   always_comb begin
      rd_val = '0;
      case (reg_addr)
         REG_CTRL:   rd_val[1]   = ctrl_ie;
         REG_MODE:   rd_val[1:0] = mode_reg;
         REG_STATUS: rd_val[2:0] = {st_err, st_done, busy};
         default:    rd_val      = perf_val;
      endcase
   end

   // read data updates only on a read strobe and holds otherwise
   always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
      if (bram_rst_a) reg_rdata <= '0;
      else if (reg_en && !reg_we) reg_rdata <= rd_val;
   end

   // registered done interrupt
   always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
      if (bram_rst_a) irq <= 1'b0;
      else irq <= st_done & ctrl_ie;
   end

endmodule

// File: tb/tb_kyber_bram_xfer_ctrl.sv
// Self-checking bench for kyber_bram_xfer_ctrl: BRAM/core models with a
// scoreboard of expected reads, core operand writes and BRAM result writes.
// Build with KYBER_XFER_PERF_EN defined to also check the RUN-cycle counter.
module tb_kyber_bram_xfer_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         reg_en = 1'b0;
   logic         reg_we = 1'b0;
   logic [1:0]   reg_addr = 2'd0;
   logic [127:0] reg_wdata = '0;
   logic [127:0] reg_rdata;
   logic         bram_en, bram_we;
   logic [8:0]   bram_addr;
   logic [127:0] bram_wdata;
   logic [127:0] bram_rdata = '0;
   logic         core_start;
   logic [1:0]   core_mode;
   logic         core_finish = 1'b0;
   logic         core_wr_en;
   logic [2:0]   core_wr_sel;
   logic [6:0]   core_wr_idx;
   logic [127:0] core_wr_data;
   logic [1:0]   core_rd_sel;
   logic [6:0]   core_rd_idx;
   logic [127:0] core_rd_data;
   logic         irq;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int first_rd_cyc = -1;
   int n_start = 0;
   int n_rd = 0;
   int n_wr = 0;

   logic [8:0]   exp_rd[$];
   logic [137:0] exp_cw[$];
   logic [136:0] exp_bw[$];

   kyber_bram_xfer_ctrl dut (
      .bram_clk_a(clk), .bram_rst_a(rst),
      .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
      .core_start(core_start), .core_mode(core_mode), .core_finish(core_finish),
      .core_wr_en(core_wr_en), .core_wr_sel(core_wr_sel), .core_wr_idx(core_wr_idx),
      .core_wr_data(core_wr_data), .core_rd_sel(core_rd_sel), .core_rd_idx(core_rd_idx),
      .core_rd_data(core_rd_data), .irq(irq)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] in_pat(input int a);
      return {32'hD00D_0000 + 32'(a), 32'h0BAD_F00D, 32'(a) ^ 32'h5555_AAAA, 32'(a * 3 + 1)};
   endfunction

   function automatic logic [127:0] res_pat(input logic [1:0] s, input logic [6:0] i);
      return {32'hBEEF_0000 | {22'd0, s, 1'b0, i}, 32'h1357_9BDF, 32'({s, i}) * 32'd97, 32'hCAFE_F00D};
   endfunction

   // core result port model and BRAM port-B model (input region only is read)
   assign core_rd_data = res_pat(core_rd_sel, core_rd_idx);

   always @(posedge clk) begin
      cyc++;
      if (bram_en && !bram_we) bram_rdata <= in_pat(int'(bram_addr));
   end

   task automatic chk(input string tag, input logic [137:0] obs, input logic [137:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // scoreboard consumer
   always @(negedge clk) begin
      if (!rst) begin
         if (core_start) n_start++;
         if (bram_en && !bram_we) begin
            n_rd++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            if (exp_rd.size() == 0) chk("rd_unexpected", 138'(bram_en), 138'(0));
            else chk("rd_addr", 138'(bram_addr), 138'(exp_rd.pop_front()));
         end
         if (core_wr_en) begin
            if (exp_cw.size() == 0) chk("cw_unexpected", 138'(core_wr_en), 138'(0));
            else chk("core_wr", {core_wr_sel, core_wr_idx, core_wr_data}, exp_cw.pop_front());
         end
         if (bram_en && bram_we) begin
            n_wr++;
            if (exp_bw.size() == 0) chk("bw_unexpected", 138'(bram_we), 138'(0));
            else chk("bram_wr", 138'({bram_addr, bram_wdata}), 138'(exp_bw.pop_front()));
         end
      end
   end

   task automatic push_load(input int sel, input int base, input int n);
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(9'(base + i));
         exp_cw.push_back({3'(sel), 7'(i), in_pat(base + i)});
      end
   endtask

   task automatic push_store(input int sel, input int base, input int n);
      for (int i = 0; i < n; i++) exp_bw.push_back({9'(base + i), res_pat(2'(sel), 7'(i))});
   endtask

   task automatic push_expect(input logic [1:0] m);
      case (m)
         2'd0: begin push_load(4, 52, 2); push_store(0, 256, 50); push_store(1, 306, 48); end
         2'd1: begin push_load(0, 0, 50); push_load(3, 50, 2); push_load(4, 52, 2); push_store(2, 354, 48); end
         2'd2: begin push_load(1, 54, 48); push_load(2, 102, 48); push_store(3, 402, 2); end
         default: ;
      endcase
   endtask

   task automatic reg_write(input logic [1:0] a, input logic [127:0] d);
      @(negedge clk);
      reg_en = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      @(negedge clk);
      reg_en = 1'b0; reg_we = 1'b0; reg_wdata = '0;
   endtask

   task automatic reg_read(input logic [1:0] a, output logic [127:0] d);
      @(negedge clk);
      reg_en = 1'b1; reg_we = 1'b0; reg_addr = a;
      @(negedge clk);
      reg_en = 1'b0;
      d = reg_rdata;
   endtask

   task automatic start_op(input logic [1:0] m, input logic ie);
      push_expect(m);
      reg_write(2'd1, 128'(m));
      first_rd_cyc = -1;
      reg_write(2'd0, 128'({ie, 1'b1}));
   endtask

   // waits for core_start, checks load length and the one-cycle pulse
   task automatic wait_start(input int nwords);
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (core_start === 1'b1) begin ok = 1; break; end
      end
      chk("core_start_seen", 138'(ok), 138'(1));
      chk("load_cycles", 138'(cyc - first_rd_cyc), 138'(nwords + 1));
      @(negedge clk);
      chk("core_start_1cyc", 138'(core_start), 138'(0));
   endtask

   task automatic finish_pulse();
      core_finish = 1'b1;
      @(negedge clk);
      core_finish = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_bw.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("drain_bw_left", 138'(exp_bw.size()), 138'(0));
      chk("drain_cw_left", 138'(exp_cw.size()), 138'(0));
   endtask

   task automatic run_mode(input logic [1:0] m, input logic ie, input int nwords);
      logic [127:0] d;
      start_op(m, ie);
      wait_start(nwords);
      repeat (19) @(negedge clk);
      finish_pulse();
      drain();
      reg_read(2'd2, d);
      chk("status_done", 138'(d), 138'(2));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] d;
      int s0, a0;

      // reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", 138'({bram_en, bram_we, bram_addr, core_start, core_mode, core_wr_en,
                                 core_rd_sel, core_rd_idx, irq}), 138'(0));
      rst = 1'b0;
      reg_read(2'd0, d); chk("rst_ctrl", 138'(d), 138'(0));
      reg_read(2'd1, d); chk("rst_mode", 138'(d), 138'(0));
      reg_read(2'd2, d); chk("rst_status", 138'(d), 138'(0));
      reg_read(2'd3, d); chk("rst_reg3", 138'(d), 138'(0));

      // mode 0 keygen, finish 20 cycles after start
      run_mode(2'd0, 1'b1, 2);
      chk("irq_keygen", 138'(irq), 138'(1));
      reg_read(2'd0, d); chk("ctrl_ie_readback", 138'(d), 138'(2));
      reg_read(2'd3, d);
`ifdef KYBER_XFER_PERF_EN
      chk("perf_run_cycles", 138'(d), 138'(20));
`else
      chk("reg3_zero", 138'(d), 138'(0));
`endif

      // mode 1 encaps and mode 2 decaps
      run_mode(2'd1, 1'b1, 54);
      chk("core_mode_encaps", 138'(core_mode), 138'(1));
      run_mode(2'd2, 1'b1, 96);

      // illegal mode: err only, no core or BRAM activity
      s0 = n_start; a0 = n_rd + n_wr;
      start_op(2'd3, 1'b1);
      repeat (10) @(negedge clk);
      chk("m3_no_start", 138'(n_start), 138'(s0));
      chk("m3_no_bram", 138'(n_rd + n_wr), 138'(a0));
      chk("m3_core_mode_kept", 138'(core_mode), 138'(2));
      reg_read(2'd2, d); chk("m3_status_err", 138'(d), 138'(6));
      reg_write(2'd2, 128'd4);
      reg_read(2'd2, d); chk("m3_err_cleared", 138'(d), 138'(2));

      // start and MODE=2 while running mode 0 are ignored
      s0 = n_start;
      start_op(2'd0, 1'b1);
      wait_start(2);
      reg_write(2'd1, 128'd2);
      reg_write(2'd0, 128'd3);
      reg_read(2'd1, d); chk("busy_mode_ignored", 138'(d), 138'(0));
      reg_read(2'd2, d); chk("busy_status", 138'(d), 138'(1));
      repeat (11) @(negedge clk);
      chk("busy_core_mode", 138'(core_mode), 138'(0));
      finish_pulse();
      drain();
      repeat (10) @(negedge clk);
      chk("busy_single_start", 138'(n_start - s0), 138'(1));
      reg_read(2'd2, d); chk("busy_done", 138'(d), 138'(2));

      // clear done, irq follows
      reg_write(2'd2, 128'd2);
      reg_read(2'd2, d); chk("done_cleared", 138'(d), 138'(0));
      chk("irq_cleared", 138'(irq), 138'(0));

      // reset in the middle of an encaps store
      start_op(2'd1, 1'b1);
      wait_start(54);
      repeat (19) @(negedge clk);
      finish_pulse();
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_outputs", 138'({bram_en, bram_we, bram_addr, core_start, core_mode, core_wr_en,
                                  core_wr_sel, core_wr_idx, core_rd_sel, core_rd_idx, irq}), 138'(0));
      chk("midrst_data", 138'({bram_wdata, core_wr_data} != '0), 138'(0));
      chk("midrst_rdata", 138'(reg_rdata), 138'(0));
      exp_rd.delete(); exp_cw.delete(); exp_bw.delete();
      @(negedge clk);
      rst = 1'b0;
      reg_read(2'd2, d); chk("midrst_status", 138'(d), 138'(0));
      reg_read(2'd1, d); chk("midrst_mode", 138'(d), 138'(0));

      // fresh operation after reset, interrupts disabled
      run_mode(2'd2, 1'b0, 96);
      chk("irq_disabled", 138'(irq), 138'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
